spike_packer: RTL and testbench
===============================

# spike_packer

Downstream of the LFSR spike encoder. Collects the 4-bit spike vector produced each valid beat, packs 8 consecutive beats into one 32-bit word, and writes the 18 words of a 144-beat frame into the spike BRAM for the SNN core. Signals frame completion, counts frames, and flags protocol violations.

## Interface
- N_BEATS, 144: valid beats per frame; must be a multiple of BEATS_PER_WORD.
- SPIKE_W, 4: spike bits per beat.
- BEATS_PER_WORD, 8: beats packed per 32-bit word. SPIKE_W*BEATS_PER_WORD = 32.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_w_run  in  1  frame-start pulse from the encoder; arrives one cycle before the first valid beat.
- i_valid  in  1  i_spike holds a beat this cycle.
- i_spike  in  4  spike bits of the current beat.
- i_err_clr  in  1  clears o_err.
- d  out  32  spike BRAM write data.
- addr  out  8  spike BRAM word address, 0..17.
- ce  out  1  spike BRAM chip enable.
- we  out  1  spike BRAM write enable; equals ce.
- o_done  out  1  one-cycle pulse when a frame is fully written.
- o_frame_cnt  out  16  completed-frame count.
- o_spike_cnt  out  10  spike popcount of the last completed frame (see Configuration).
- o_err  out  1  sticky protocol error.

## Operation
- States: S_IDLE, S_PACK, S_FLUSH, S_DONE.
- S_IDLE: i_w_run -> S_PACK. Beat counter, word index, and shift register are cleared. i_valid without i_w_run is ignored and sets o_err.
- S_PACK:
  - Each i_valid beat places i_spike at bits [k*4 +: 4] of the word, where k = beat index mod 8. Beat 0 of a word goes to bits [3:0].
  - On beat k = 7, the completed word is registered into d with addr = word index, and ce = we = 1 for the following cycle. The word index then increments.
  - When i_valid is low, nothing advances. Gaps are legal.
  - After beat N_BEATS-1 -> S_FLUSH.
- S_FLUSH: the last write (addr 17) is on the bus. -> S_DONE.
- S_DONE: o_done = 1; o_frame_cnt increments (wraps 65535 -> 0); o_spike_cnt updates. -> S_IDLE.
- i_w_run in S_PACK, S_FLUSH, or S_DONE:
  - Sets o_err.
  - In S_PACK, aborts the current frame: counters clear and packing restarts at word 0. The aborted frame is not counted.
  - In S_FLUSH or S_DONE, the pending write and done still complete, then the FSM enters S_PACK directly.
- i_valid in S_FLUSH or S_DONE sets o_err; the beat is dropped.
- Rest frames (all-zero spikes) are packed and written like any other frame.
- o_err is cleared by i_err_clr. If a set event and i_err_clr occur in the same cycle, set wins.

## Timing
- Reset values: d = 0, addr = 0, ce = 0, we = 0, o_done = 0, o_frame_cnt = 0, o_spike_cnt = 0, o_err = 0, state = S_IDLE.
- Write latency: 1 cycle after the 8th beat of a word.
- With back-to-back beats, the first valid beat is at cycle T0:
  - Writes occur at T0+8, T0+16, …, T0+144.
  - S_FLUSH is at T0+144.
  - o_done is at T0+145.
  - S_IDLE is at T0+146.
- The earliest accepted next i_w_run is at T0+144.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Reset mid-frame: all state is discarded immediately. BRAM contents are undefined for that frame.

## Configuration
- SPIKE_POPCNT_EN defined:
  - A 10-bit accumulator adds popcount(i_spike) on every accepted beat.
  - The sum is latched to o_spike_cnt in S_DONE.
  - The accumulator clears on i_w_run and on abort.
  - Maximum value is 576.
- SPIKE_POPCNT_EN undefined: the accumulator is not built and o_spike_cnt is tied to 0.

## Test plan
- Reset, then i_w_run followed by 144 beats with i_spike = 4'hF: expect 18 writes, each d = 32'hFFFF_FFFF, addr 0..17; o_done at T0+145; o_frame_cnt = 1; o_spike_cnt = 576 with SPIKE_POPCNT_EN defined.
- Beats with i_spike = beat index mod 16: word 0 must read 32'h7654_3210 and word 1 must read 32'hFEDC_BA98.
- i_valid toggled every other cycle during a frame: same 18 words as back-to-back; o_done at the cycle after the write to addr 17.
- i_w_run reasserted after 50 beats, then a full frame of 4'h1: o_err = 1; o_frame_cnt increments by 1 only; the words read 32'h1111_1111; i_err_clr returns o_err to 0.
- i_valid pulses while in S_IDLE: no ce; o_err = 1; o_frame_cnt unchanged.
- rst_n asserted after 70 beats: all outputs return to reset values immediately; the next full frame completes normally with o_frame_cnt = 1.

Source files
------------

// File: rtl/spike_packer.sv
`default_nettype none
// ============================================================================
// Module   : spike_packer
// Purpose  : Packs 4-bit spike beats from the LFSR encoder, eight per 32-bit
//            word, and writes the 18 words of a 144-beat frame into the spike
//            BRAM. Reports frame completion, counts frames and flags protocol
//            violations (sticky o_err).
// Options  : SPIKE_POPCNT_EN - when defined, accumulates the spike popcount of
//            each frame and presents it on o_spike_cnt; otherwise o_spike_cnt
//            is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module spike_packer #(
  parameter int N_BEATS        = 144,
  parameter int SPIKE_W        = 4,
  parameter int BEATS_PER_WORD = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              i_w_run,
  input  logic                              i_valid,
  input  logic [SPIKE_W-1:0]                i_spike,
  input  logic                              i_err_clr,
  output logic [SPIKE_W*BEATS_PER_WORD-1:0] d,
  output logic [7:0]                        addr,
  output logic                              ce,
  output logic                              we,
  output logic                              o_done,
  output logic [15:0]                       o_frame_cnt,
  output logic [9:0]                        o_spike_cnt,
  output logic                              o_err
);

  localparam int WORD_W = SPIKE_W * BEATS_PER_WORD;
  localparam int KW     = $clog2(BEATS_PER_WORD);
  localparam int BEAT_W = $clog2(N_BEATS);
  localparam int WIDX_W = BEAT_W - KW;
  localparam int ADDR_W = 8;
  localparam int CNT_W  = 10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PACK  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [WORD_W-1:0]   shift_q, shift_d;
  logic [WORD_W-1:0]   data_q, data_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                ce_q, ce_d;
  logic                done_q, done_d;
  logic [15:0]         frame_q, frame_d;
  logic                err_q, err_d;
  logic                pend_q, pend_d;

  logic                w_start;
  logic                w_set_err;
  logic [KW-1:0]       w_k;
  logic [WIDX_W-1:0]   w_widx;
  logic [WORD_W-1:0]   w_word;

  // Beat position within the word and word index come straight from the beat counter
  assign w_k    = beat_q[KW-1:0];
  assign w_widx = beat_q[BEAT_W-1:KW];

  // Next-state, packing datapath, BRAM write and error bookkeeping
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    shift_d   = shift_q;
    data_d    = data_q;
    addr_d    = addr_q;
    ce_d      = 1'b0;
    done_d    = 1'b0;
    frame_d   = frame_q;
    err_d     = err_q;
    pend_d    = pend_q;
    w_start   = 1'b0;
    w_set_err = 1'b0;

    // Current word with this beat's nibble merged in at position k
    w_word = shift_q;
    w_word[w_k*SPIKE_W +: SPIKE_W] = i_spike;

    case (state_q)
      S_IDLE: begin
        if (i_w_run) begin
          state_d = S_PACK;
          w_start = 1'b1;
        end else if (i_valid) begin
          w_set_err = 1'b1;
        end
      end
      S_PACK: begin
        if (i_w_run) begin
          // Abort: restart the frame at word 0; a coincident beat is dropped
          w_set_err = 1'b1;
          w_start   = 1'b1;
        end else if (i_valid) begin
          if (w_k == KW'(BEATS_PER_WORD - 1)) begin
            data_d  = w_word;
            addr_d  = ADDR_W'(w_widx);
            ce_d    = 1'b1;
            shift_d = '0;
          end else begin
            shift_d = w_word;
          end
          if (beat_q == BEAT_W'(N_BEATS - 1)) begin
            beat_d  = '0;
            state_d = S_FLUSH;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      S_FLUSH: begin
        state_d = S_DONE;
        done_d  = 1'b1;
        frame_d = frame_q + 16'd1;
        if (i_w_run) begin
          // Remember the early frame start so DONE can go straight to PACK
          pend_d    = 1'b1;
          w_set_err = 1'b1;
        end
        if (i_valid) begin
          w_set_err = 1'b1;
        end
      end
      S_DONE: begin
        pend_d = 1'b0;
        if (i_w_run || pend_q) begin
          state_d = S_PACK;
          w_start = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
        if (i_w_run || i_valid) begin
          w_set_err = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (w_start) begin
      beat_d  = '0;
      shift_d = '0;
    end

    // A set event in the same cycle as a clear keeps the flag set
    if (w_set_err) begin
      err_d = 1'b1;
    end else if (i_err_clr) begin
      err_d = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      shift_q <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      ce_q    <= 1'b0;
      done_q  <= 1'b0;
      frame_q <= '0;
      err_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      ce_q    <= ce_d;
      done_q  <= done_d;
      frame_q <= frame_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
    end
  end

`ifdef SPIKE_POPCNT_EN
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] spk_q, spk_d;
  logic [CNT_W-1:0] w_pop;

  // Accumulate the popcount of accepted beats; latch the total as the frame completes
  always_comb begin
    w_pop = '0;
    for (int b = 0; b < SPIKE_W; b++) begin
      w_pop = w_pop + CNT_W'(i_spike[b]);
    end
    acc_d = acc_q;
    spk_d = spk_q;
    if (w_start) begin
      acc_d = '0;
    end else if ((state_q == S_PACK) && i_valid) begin
      acc_d = acc_q + w_pop;
    end
    if (state_q == S_FLUSH) begin
      spk_d = acc_q;
    end
  end

  // Popcount registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      spk_q <= '0;
    end else begin
      acc_q <= acc_d;
      spk_q <= spk_d;
    end
  end

  assign o_spike_cnt = spk_q;
`else
  assign o_spike_cnt = '0;
`endif

  assign d           = data_q;
  assign addr        = addr_q;
  assign ce          = ce_q;
  assign we          = ce_q;
  assign o_done      = done_q;
  assign o_frame_cnt = frame_q;
  assign o_err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_spike_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_spike_packer
// Purpose  : Directed self-checking bench for spike_packer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spike_packer;

  logic        clk;
  logic        rst_n;
  logic        i_w_run;
  logic        i_valid;
  logic [3:0]  i_spike;
  logic        i_err_clr;
  logic [31:0] d;
  logic [7:0]  addr;
  logic        ce;
  logic        we;
  logic        o_done;
  logic [15:0] o_frame_cnt;
  logic [9:0]  o_spike_cnt;
  logic        o_err;

  spike_packer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_w_run     (i_w_run),
    .i_valid     (i_valid),
    .i_spike     (i_spike),
    .i_err_clr   (i_err_clr),
    .d           (d),
    .addr        (addr),
    .ce          (ce),
    .we          (we),
    .o_done      (o_done),
    .o_frame_cnt (o_frame_cnt),
    .o_spike_cnt (o_spike_cnt),
    .o_err       (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int          n_chk  = 0;
  int          n_pass = 0;
  int          wr_n   = 0;
  int          done_n = 0;
  int          done_cyc = 0;
  logic [7:0]  wr_addr [256];
  logic [31:0] wr_data [256];
  logic        wr_we   [256];
  int          wr_cyc  [256];
  int          base_wr;
  int          t0;
  int          done0;

  // Log every BRAM write and done pulse, sampled mid-cycle
  always @(negedge clk) begin
    if (ce && wr_n < 256) begin
      wr_addr[wr_n] = addr;
      wr_data[wr_n] = d;
      wr_we[wr_n]   = we;
      wr_cyc[wr_n]  = cyc;
      wr_n++;
    end
    if (o_done) begin
      done_n++;
      done_cyc = cyc;
    end
  end

  function automatic logic [31:0] exp_spk(input int v);
`ifdef SPIKE_POPCNT_EN
    return v;
`else
    return (v == 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Frame start pulse followed by n beats; idx selects spike = beat mod 16
  task automatic frame(input int n, input bit idx, input logic [3:0] val, input bit gap);
    step();
    i_w_run = 1'b1;
    i_valid = 1'b0;
    base_wr = wr_n;
    done0   = done_n;
    step();
    i_w_run = 1'b0;
    t0 = cyc;
    for (int b = 0; b < n; b++) begin
      i_valid = 1'b1;
      i_spike = idx ? b[3:0] : val;
      step();
      if (gap) begin
        i_valid = 1'b0;
        step();
      end
    end
    i_valid = 1'b0;
  endtask

  task automatic chk_words(input logic [31:0] w0, input logic [31:0] w1);
    chk("write_count", wr_n - base_wr, 18);
    for (int i = 0; i < 18; i++) begin
      chk($sformatf("addr[%0d]", i), wr_addr[base_wr + i], i);
      chk($sformatf("data[%0d]", i), wr_data[base_wr + i], (i % 2 == 1) ? w1 : w0);
      chk($sformatf("we[%0d]", i), wr_we[base_wr + i], 1);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_d"}, d, 0);
    chk({tag, "_addr"}, addr, 0);
    chk({tag, "_ce"}, ce, 0);
    chk({tag, "_we"}, we, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_frame_cnt"}, o_frame_cnt, 0);
    chk({tag, "_spike_cnt"}, o_spike_cnt, 0);
    chk({tag, "_err"}, o_err, 0);
  endtask

  initial begin
    int base;
    rst_n     = 1'b0;
    i_w_run   = 1'b0;
    i_valid   = 1'b0;
    i_spike   = 4'h0;
    i_err_clr = 1'b0;
    repeat (3) step();
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    step();

    // Back-to-back frame of all-ones spikes
    frame(144, 1'b0, 4'hF, 1'b0);
    repeat (4) step();
    chk_words(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("first_write_cycle", wr_cyc[base_wr] - t0, 8);
    chk("last_write_cycle", wr_cyc[base_wr + 17] - t0, 144);
    chk("done_count", done_n - done0, 1);
    chk("done_cycle", done_cyc - t0, 145);
    chk("frame_cnt_1", o_frame_cnt, 1);
    chk("spike_cnt_ff", o_spike_cnt, exp_spk(576));
    chk("err_after_f1", o_err, 0);

    // Beat-index pattern: nibble order check
    frame(144, 1'b1, 4'h0, 1'b0);
    repeat (4) step();
    chk("word0_idx", wr_data[base_wr], 32'h7654_3210);
    chk("word1_idx", wr_data[base_wr + 1], 32'hFEDC_BA98);
    chk_words(32'h7654_3210, 32'hFEDC_BA98);
    chk("frame_cnt_2", o_frame_cnt, 2);
    chk("spike_cnt_idx", o_spike_cnt, exp_spk(288));

    // Valid toggled every other cycle
    frame(144, 1'b1, 4'h0, 1'b1);
    repeat (4) step();
    chk_words(32'h7654_3210, 32'hFEDC_BA98);
    chk("gap_last_write_cycle", wr_cyc[base_wr + 17] - t0, 287);
    chk("gap_done_after_last_write", done_cyc - wr_cyc[base_wr + 17], 1);
    chk("frame_cnt_3", o_frame_cnt, 3);
    chk("err_after_gap", o_err, 0);

    // Abort after 50 beats, then a full frame of 4'h1
    frame(50, 1'b0, 4'h1, 1'b0);
    frame(144, 1'b0, 4'h1, 1'b0);
    repeat (4) step();
    chk_words(32'h1111_1111, 32'h1111_1111);
    chk("abort_err", o_err, 1);
    chk("abort_frame_cnt", o_frame_cnt, 4);
    chk("abort_spike_cnt", o_spike_cnt, exp_spk(144));
    i_err_clr = 1'b1;
    step();
    i_err_clr = 1'b0;
    chk("err_cleared", o_err, 0);

    // Valid pulses while idle
    base = wr_n;
    i_valid = 1'b1;
    i_spike = 4'hA;
    repeat (3) step();
    i_valid = 1'b0;
    repeat (3) step();
    chk("idle_no_write", wr_n - base, 0);
    chk("idle_err", o_err, 1);
    chk("idle_frame_cnt", o_frame_cnt, 4);
    i_err_clr = 1'b1;
    step();
    i_err_clr = 1'b0;
    chk("idle_err_cleared", o_err, 0);

    // Reset in the middle of a frame
    frame(70, 1'b0, 4'hF, 1'b0);
    chk("pre_reset_addr", addr, 7);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    step();
    rst_n = 1'b1;
    frame(144, 1'b0, 4'h5, 1'b0);
    repeat (4) step();
    chk_words(32'h5555_5555, 32'h5555_5555);
    chk("post_reset_frame_cnt", o_frame_cnt, 1);
    chk("post_reset_spike_cnt", o_spike_cnt, exp_spk(288));
    chk("post_reset_err", o_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
